// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: register file geometry, zero constants and enable levels.
package cpu_defs_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [DATA_W-1:0]     ZERO_WORD = 32'h0;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO  = 5'd0;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO special register pair, written atomically; cleared by synchronous reset.
module hilo_reg #(
    parameter int DATA_W = cpu_defs_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hilo_we,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);
    import cpu_defs_pkg::*;

    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (hilo_we == WRITE_ENABLE) begin
            hi <= hi_in;
            lo <= lo_in;
        end
    end

    assign hi_out = hi;
    assign lo_out = lo;

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: 32 GPRs with two combinational read ports plus HI/LO.
// Define WB_REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module wb_regfile #(
    parameter int DATA_W = cpu_defs_pkg::DATA_W,
    parameter int ADDR_W = cpu_defs_pkg::REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              hilo_we,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);
    import cpu_defs_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] gpr [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            gpr <= '{default: '0};
        end else if (we == WRITE_ENABLE && waddr != REG_ZERO) begin
            gpr[waddr] <= wdata;
        end
    end

    // Register 0 and disabled ports read as zero regardless of array contents or bypass.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] value;
        value = ZERO_WORD;
        if (!reset && re == READ_ENABLE && raddr != REG_ZERO) begin
`ifdef WB_REGFILE_BYPASS_EN
            if (we == WRITE_ENABLE && raddr == waddr) begin
                value = wdata;
            end else begin
                value = stored;
            end
`else
            value = stored;
`endif
        end
        return value;
    endfunction

    always_comb begin
        rdata1 = read_port(re1, raddr1, gpr[raddr1]);
    end

    always_comb begin
        rdata2 = read_port(re2, raddr2, gpr[raddr2]);
    end

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo_reg (
        .clk     (clk),
        .reset   (reset),
        .hilo_we (hilo_we),
        .hi_in   (hi_in),
        .lo_in   (lo_in),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized bench for wb_regfile against an array-based reference model, plus literal directed cases.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hilo_we;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    logic [31:0] mdl [32];
    logic [31:0] mhi;
    logic [31:0] mlo;

    wb_regfile dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .hilo_we (hilo_we),
        .hi_in   (hi_in),
        .lo_in   (lo_in),
        .re1     (re1),
        .raddr1  (raddr1),
        .rdata1  (rdata1),
        .re2     (re2),
        .raddr2  (raddr2),
        .rdata2  (rdata2),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference state: what each register holds after each edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mdl[i] <= 32'h0;
            mhi <= 32'h0;
            mlo <= 32'h0;
        end else begin
            if (we && waddr != 5'd0) mdl[waddr] <= wdata;
            if (hilo_we) begin
                mhi <= hi_in;
                mlo <= lo_in;
            end
        end
    end

    function automatic logic [31:0] exp_read(input logic re, input logic [4:0] ra);
        if (reset || !re || ra == 5'd0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
        if (we && ra == waddr) return wdata;
`endif
        return mdl[ra];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("rdata1", rdata1, exp_read(re1, raddr1));
            check("rdata2", rdata2, exp_read(re2, raddr2));
            check("hi_out", hi_out, mhi);
            check("lo_out", lo_out, mlo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        hilo_we = 1'b0; hi_in = '0; lo_in = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        tick();
        chk_en = 1;

        // reset then read
        reset = 1'b0; re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd31;
        #2;
        check("rst_rd1", rdata1, 32'h0);
        check("rst_rd2", rdata2, 32'h0);
        check("rst_hi", hi_out, 32'h0);
        check("rst_lo", lo_out, 32'h0);

        // basic write then read
        we = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF; re1 = 1'b0; re2 = 1'b0;
        tick();
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b0; raddr2 = 5'd7;
        #2;
        check("wr7_rd1", rdata1, 32'hDEADBEEF);
        check("wr7_re2off", rdata2, 32'h0);

        // register zero, same cycle and after the edge
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; re1 = 1'b1; raddr1 = 5'd0;
        re2 = 1'b1; raddr2 = 5'd0;
        #2;
        check("r0_same", rdata1, 32'h0);
        tick();
        we = 1'b0;
        #2;
        check("r0_after", rdata1, 32'h0);
        check("r0_after2", rdata2, 32'h0);

        // same-cycle read-after-write on reg 3
        we = 1'b1; waddr = 5'd3; wdata = 32'h11111111;
        tick();
        wdata = 32'h22222222; raddr1 = 5'd3; raddr2 = 5'd3;
        #2;
`ifdef WB_REGFILE_BYPASS_EN
        check("raw3_same", rdata1, 32'h22222222);
        check("raw3_same2", rdata2, 32'h22222222);
`else
        check("raw3_same", rdata1, 32'h11111111);
        check("raw3_same2", rdata2, 32'h11111111);
`endif
        tick();
        we = 1'b0;
        #2;
        check("raw3_after", rdata1, 32'h22222222);

        // HI/LO with concurrent GPR write
        hilo_we = 1'b1; hi_in = 32'hA5A5A5A5; lo_in = 32'h5A5A5A5A;
        we = 1'b1; waddr = 5'd9; wdata = 32'h1;
        tick();
        hilo_we = 1'b0; hi_in = 32'h01234567; lo_in = 32'h89ABCDEF; we = 1'b0;
        raddr1 = 5'd9;
        #2;
        check("hilo_hi", hi_out, 32'hA5A5A5A5);
        check("hilo_lo", lo_out, 32'h5A5A5A5A);
        check("hilo_r9", rdata1, 32'h1);
        tick();
        #2;
        check("hold_hi", hi_out, 32'hA5A5A5A5);
        check("hold_lo", lo_out, 32'h5A5A5A5A);

        // reset priority over simultaneous writes
        reset = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h12345678;
        hilo_we = 1'b1; hi_in = 32'hCAFEF00D; lo_in = 32'hBADC0FFE; raddr1 = 5'd9;
        #2;
        check("rstforce_rd1", rdata1, 32'h0);
        tick();
        reset = 1'b0; we = 1'b0; hilo_we = 1'b0; raddr1 = 5'd4; raddr2 = 5'd9;
        #2;
        check("rstpri_r4", rdata1, 32'h0);
        check("rstpri_r9", rdata2, 32'h0);
        check("rstpri_hi", hi_out, 32'h0);
        check("rstpri_lo", lo_out, 32'h0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset   = ($urandom_range(0, 63) == 0);
            we      = ($urandom_range(0, 1) == 1);
            waddr   = 5'($urandom_range(0, 31));
            wdata   = $urandom;
            hilo_we = ($urandom_range(0, 3) == 0);
            hi_in   = $urandom;
            lo_in   = $urandom;
            re1     = ($urandom_range(0, 7) != 0);
            re2     = ($urandom_range(0, 7) != 0);
            raddr1  = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2  = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            tick();
        end

        reset = 1'b0; we = 1'b0; hilo_we = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back sink for the MEM/WB pipeline register: general-purpose register file (32 x 32) plus HI/LO special registers.
- Write port consumes the registered write-back bundle (target address, write enable, data, hilo enable, hi, lo).
- Two combinational read ports serve the decode stage.
- HI/LO read-out feeds the execute stage for mfhi/mflo.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register index width; register count = 2**ADDR_W.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- we  input  1  GPR write enable from MEM/WB stage.
- waddr  input  ADDR_W  GPR write index.
- wdata  input  DATA_W  GPR write data.
- hilo_we  input  1  HI/LO write enable.
- hi_in  input  DATA_W  HI write data.
- lo_in  input  DATA_W  LO write data.
- re1  input  1  read port 1 enable.
- raddr1  input  ADDR_W  read port 1 index.
- rdata1  output  DATA_W  read port 1 data.
- re2  input  1  read port 2 enable.
- raddr2  input  ADDR_W  read port 2 index.
- rdata2  output  DATA_W  read port 2 data.
- hi_out  output  DATA_W  current HI.
- lo_out  output  DATA_W  current LO.

Behaviour:
- Reset: on the rising edge with reset=1, all GPRs, HI and LO are cleared to 0.
  - While reset=1, rdata1/rdata2 are forced to 0 combinationally.
  - hi_out/lo_out show the stored value, which is 0 one edge after reset.
- GPR write: on the rising edge with we=1, waddr!=0 and reset=0, reg[waddr] <= wdata. Write latency is 1 edge.
- Register 0 is hardwired to 0:
  - writes to index 0 are discarded;
  - reads of index 0 always return 0, bypass included.
- Read ports are purely combinational.
  - reN=0 -> rdataN=0.
  - reN=1 -> rdataN = reg[raddrN], or the bypass value (see Optional Feature).
- Both read ports may address the same register in the same cycle; both return identical data.
- HI/LO: on the rising edge with hilo_we=1 and reset=0, hi <= hi_in and lo <= lo_in, written atomically as a pair.
  - hi_out/lo_out are driven directly from the stored registers, with no forwarding.
  - HI/LO hazards are resolved upstream.
- GPR and HI/LO writes are independent and may occur in the same cycle.
- Reset has priority over any simultaneous write: we=1 or hilo_we=1 during reset has no effect.
- Reset asserted mid-stream discards the in-flight write in that cycle; stored state is lost.
- There is no stall or flush input. Every asserted we is honoured.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If reset=0, reN=1, we=1, raddrN==waddr and waddr!=0, then rdataN = wdata in the same cycle. This removes the WB->ID hazard.
- Undefined: rdataN returns the stored value. A same-cycle write becomes visible only after the next rising edge, so decode must stall or forward externally.

Decomposition:
- Shared package (cpu_defs_pkg) holds:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32;
  - ZERO_WORD=32'h0, REG_ZERO=5'd0;
  - write-enable/read-enable asserted/deasserted constants.
- Natural sub-module: hilo_reg.
  - Holds the HI/LO pair and its synchronous reset/write.
  - Instantiated once inside wb_regfile.
- GPR array and read muxes stay in the top.

Test Plan:
- Reset then read: pulse reset 1 cycle, set re1=re2=1 with raddr1=5, raddr2=31 -> rdata1=rdata2=0; hi_out=lo_out=0.
- Basic write/read: we=1, waddr=7, wdata=32'hDEADBEEF for 1 edge, then re1=1, raddr1=7 -> rdata1=32'hDEADBEEF; re2=0 -> rdata2=0.
- Register zero: we=1, waddr=0, wdata=32'hFFFFFFFF, then read raddr1=0 -> 0. This holds in both builds, including the same-cycle bypass case.
- Same-cycle read-after-write on reg 3 (old value 32'h11111111, new 32'h22222222):
  - WB_REGFILE_BYPASS_EN defined -> rdata1=32'h22222222 in the write cycle.
  - Undefined -> 32'h11111111 in the write cycle, 32'h22222222 after the edge.
- HI/LO: hilo_we=1, hi_in=32'hA5A5A5A5, lo_in=32'h5A5A5A5A together with GPR write reg 9=32'h1 -> after the edge, hi_out/lo_out show the new values and reg 9 reads 32'h1. With hilo_we=0 the next cycle, the values hold.
- Reset priority: reset=1 with we=1 (waddr=4, wdata=32'h12345678) and hilo_we=1 -> after the edge, reg 4, HI and LO are all 0.
